// File: rtl/lock_reset_seq.sv
// Power-up reset sequencer: waits for stable PLL/BUFPLL lock, holds reset, waits for MCB calibration.
// Optional relock_cnt output and counter enabled by defining LOCK_RELOCK_CNT_EN.
module lock_reset_seq #(
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned RESET_HOLD_CYCLES  = 16,
    parameter int unsigned CALIB_TIMEOUT      = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_lock,
    input  logic       bufpll_mcb_lock,
    input  logic       calib_done,
    input  logic       lock_lost_clr,
    output logic       reset_frame_buf,
    output logic       lock_lost,
    output logic       calib_timeout
`ifdef LOCK_RELOCK_CNT_EN
    ,
    output logic [7:0] relock_cnt
`endif
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST  = CNT_W'(CALIB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        STABLE,
        HOLD,
        WAIT_CALIB,
        RUN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       pll_sync;
    logic [1:0]       bufpll_sync;
    logic [1:0]       calib_sync;
    logic             lock_ok;
    logic             calib_ok;
    logic             lock_loss;

    // Two-flop synchronizers for the asynchronous status inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pll_sync    <= '0;
            bufpll_sync <= '0;
            calib_sync  <= '0;
        end else begin
            pll_sync    <= {pll_sync[0], pll_lock};
            bufpll_sync <= {bufpll_sync[0], bufpll_mcb_lock};
            calib_sync  <= {calib_sync[0], calib_done};
        end
    end

    assign lock_ok   = pll_sync[1] & bufpll_sync[1];
    assign calib_ok  = calib_sync[1];
    assign lock_loss = (state == RUN) && !lock_ok;

    // Sequencer; the counter returns to zero whenever it is not explicitly advanced
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            reset_frame_buf <= 1'b1;
            lock_lost       <= 1'b0;
            calib_timeout   <= 1'b0;
        end else begin
            calib_timeout   <= 1'b0;
            reset_frame_buf <= 1'b1;
            cnt             <= '0;

            if (lock_loss) begin
                lock_lost <= 1'b1;
            end else if (lock_lost_clr) begin
                lock_lost <= 1'b0;
            end

            if (state != IDLE && !lock_ok) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (lock_ok) state <= STABLE;
                    end
                    STABLE: begin
                        if (cnt == STABLE_LAST) state <= HOLD;
                        else                    cnt   <= cnt + CNT_W'(1);
                    end
                    HOLD: begin
                        if (cnt == HOLD_LAST) state <= WAIT_CALIB;
                        else                  cnt   <= cnt + CNT_W'(1);
                    end
                    WAIT_CALIB: begin
                        if (calib_ok) begin
                            state           <= RUN;
                            reset_frame_buf <= 1'b0;
                        end else if (cnt == CALIB_LAST) begin
                            state         <= IDLE;
                            calib_timeout <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        reset_frame_buf <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef LOCK_RELOCK_CNT_EN
    // Saturating count of lock drops while running; only reset_n clears it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            relock_cnt <= '0;
        end else if (lock_loss && (relock_cnt != 8'hFF)) begin
            relock_cnt <= relock_cnt + 8'd1;
        end
    end
`else
    // Relock counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_lock_reset_seq.sv
// Scoreboard bench for lock_reset_seq: stimulus queues expected output events, a monitor checks them.
module tb_lock_reset_seq;

    localparam int LSC = 8;
    localparam int RHC = 4;
    localparam int CTO = 32;
    localparam int LAT = 2 + 1 + LSC + RHC + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pll_lock = 1'b0;
    logic bufpll_mcb_lock = 1'b0;
    logic calib_done = 1'b1;
    logic lock_lost_clr = 1'b0;
    logic reset_frame_buf;
    logic lock_lost;
    logic calib_timeout;
`ifdef LOCK_RELOCK_CNT_EN
    logic [7:0] relock_cnt;
`endif

    lock_reset_seq #(
        .LOCK_STABLE_CYCLES(LSC),
        .RESET_HOLD_CYCLES (RHC),
        .CALIB_TIMEOUT     (CTO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_lock       (pll_lock),
        .bufpll_mcb_lock(bufpll_mcb_lock),
        .calib_done     (calib_done),
        .lock_lost_clr  (lock_lost_clr),
        .reset_frame_buf(reset_frame_buf),
        .lock_lost      (lock_lost),
        .calib_timeout  (calib_timeout)
`ifdef LOCK_RELOCK_CNT_EN
        ,
        .relock_cnt     (relock_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    typedef enum int {E_RFB_FALL, E_RFB_RISE, E_LL_SET, E_LL_CLR, E_TO} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       cyc;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  ll_model = 1'b0;
    int  losses = 0;
    logic prev_rfb = 1'b1;
    logic prev_ll = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input ev_kind_e k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic observe(input ev_kind_e k);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual=%s@%0d required=none", k.name(), cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                failures++;
                $display("FAIL event actual=%s@%0d required=%s@%0d",
                         k.name(), cyc, e.kind.name(), e.cyc);
            end
        end
    endtask

    // Monitor: every output change (and every timeout pulse cycle) is an observed event
    initial forever begin
        @(negedge clk);
        if (reset_frame_buf !== prev_rfb) begin
            prev_rfb = reset_frame_buf;
            observe(reset_frame_buf ? E_RFB_RISE : E_RFB_FALL);
        end
        if (lock_lost !== prev_ll) begin
            prev_ll = lock_lost;
            observe(lock_lost ? E_LL_SET : E_LL_CLR);
        end
        if (calib_timeout === 1'b1) observe(E_TO);
    end

    task automatic wait_empty(input string name, input int bound);
        int i = 0;
        while (sb.size() != 0 && i < bound) begin
            tick(1);
            i++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout actual_pending=%0d required_pending=0", name, sb.size());
            sb.delete();
        end
    endtask

    // Drop both locks while running: reset re-asserts 3 cycles later, lock_lost sets
    task automatic drop_locks_run();
        int m = cyc;
        expect_ev(E_RFB_RISE, m + 3);
        if (!ll_model) begin
            expect_ev(E_LL_SET, m + 3);
            ll_model = 1'b1;
        end
        pll_lock        = 1'b0;
        bufpll_mcb_lock = 1'b0;
        losses++;
    endtask

    // Lock glitch of len cycles while running; full sequence restarts afterwards
    task automatic glitch(input int which, input int len);
        int m = cyc;
        expect_ev(E_RFB_RISE, m + 3);
        if (!ll_model) begin
            expect_ev(E_LL_SET, m + 3);
            ll_model = 1'b1;
        end
        expect_ev(E_RFB_FALL, m + len + LAT);
        if (which != 1) pll_lock = 1'b0;
        if (which != 0) bufpll_mcb_lock = 1'b0;
        tick(len);
        pll_lock        = 1'b1;
        bufpll_mcb_lock = 1'b1;
        losses++;
    endtask

    task automatic clear_pulse();
        expect_ev(E_LL_CLR, cyc + 1);
        lock_lost_clr = 1'b1;
        tick(1);
        lock_lost_clr = 1'b0;
        ll_model = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;
        int k_off;

        tick(3);
        check("reset_rfb", reset_frame_buf, 1);
        check("reset_lock_lost", lock_lost, 0);
        check("reset_calib_timeout", calib_timeout, 0);
`ifdef LOCK_RELOCK_CNT_EN
        check("reset_relock_cnt", relock_cnt, 0);
`endif
        reset_n = 1'b1;
        tick(4 + $urandom_range(0, 5));

        // First release with calibration already done
        n = cyc;
        expect_ev(E_RFB_FALL, n + LAT);
        pll_lock        = 1'b1;
        bufpll_mcb_lock = 1'b1;
        wait_empty("first_release", 40);
        check("run_rfb_low", reset_frame_buf, 0);

        // calib_done dropping in RUN is ignored
        calib_done = 1'b0;
        tick($urandom_range(3, 8));
        check("run_ignores_calib", reset_frame_buf, 0);
        calib_done = 1'b1;
        tick(4);

        glitch(1, 1);
        wait_empty("bufpll_drop", 40);
`ifdef LOCK_RELOCK_CNT_EN
        check("relock_cnt_one", relock_cnt, 1);
`endif
        clear_pulse();
        wait_empty("lock_lost_clear", 5);

        // Clear and set on the same edge: set wins
        m = cyc;
        expect_ev(E_RFB_RISE, m + 3);
        expect_ev(E_LL_SET, m + 3);
        expect_ev(E_RFB_FALL, m + 1 + LAT);
        ll_model = 1'b1;
        bufpll_mcb_lock = 1'b0;
        tick(1);
        bufpll_mcb_lock = 1'b1;
        tick(1);
        lock_lost_clr = 1'b1;
        tick(1);
        lock_lost_clr = 1'b0;
        losses++;
        wait_empty("set_wins", 40);

        // Many randomized lock losses in RUN, with occasional clears
        while (losses < 260) begin
            tick($urandom_range(0, 3));
            if (ll_model && ($urandom_range(0, 1) == 1)) clear_pulse();
            glitch($urandom_range(0, 2), $urandom_range(1, 3));
            wait_empty("loss_loop", 40);
        end
`ifdef LOCK_RELOCK_CNT_EN
        check("relock_cnt_saturated", relock_cnt, 255);
`endif
        check("lock_lost_after_loop", lock_lost, 1);

        // One-cycle pll glitch while counting STABLE
        for (int it = 0; it < 2; it++) begin
            drop_locks_run();
            tick(6);
            wait_empty("drop_before_stable", 10);
            n = cyc;
            k_off = (it == 0) ? 6 : $urandom_range(1, 13);
            pll_lock        = 1'b1;
            bufpll_mcb_lock = 1'b1;
            tick(k_off);
            pll_lock = 1'b0;
            tick(1);
            pll_lock = 1'b1;
            expect_ev(E_RFB_FALL, n + k_off + 1 + LAT);
            wait_empty("stable_glitch", 60);
        end

        // Calibration never completes: one timeout pulse, no release
        drop_locks_run();
        calib_done = 1'b0;
        tick(6);
        wait_empty("drop_before_timeout", 10);
        n = cyc;
        expect_ev(E_TO, n + 3 + LSC + RHC + CTO);
        pll_lock        = 1'b1;
        bufpll_mcb_lock = 1'b1;
        wait_empty("calib_timeout", 70);
        pll_lock        = 1'b0;
        bufpll_mcb_lock = 1'b0;
        tick(50);
        check("timeout_rfb_high", reset_frame_buf, 1);
        check("timeout_pulse_low", calib_timeout, 0);
        calib_done = 1'b1;
        tick(4);

        // Asynchronous reset during HOLD, then a full restart
        n = cyc;
        pll_lock        = 1'b1;
        bufpll_mcb_lock = 1'b1;
        tick(12);
        expect_ev(E_LL_CLR, cyc);
        reset_n = 1'b0;
        #1;
        check("midreset_rfb", reset_frame_buf, 1);
        check("midreset_lock_lost", lock_lost, 0);
        check("midreset_calib_timeout", calib_timeout, 0);
`ifdef LOCK_RELOCK_CNT_EN
        check("midreset_relock_cnt", relock_cnt, 0);
`endif
        ll_model = 1'b0;
        tick(1);
        reset_n = 1'b1;
        expect_ev(E_RFB_FALL, cyc + LAT);
        wait_empty("restart_after_reset", 40);

        drop_locks_run();
        tick(6);
        wait_empty("final_drop", 10);
        check("final_queue_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
